axi_stream_protocol_checker: RTL and testbench

//  Synthesizable AXI4-Stream checker. Taps one stream passively (no outputs onto the bus)
//  and reports protocol violations as sticky error flags, plus beat/byte/packet statistics.

---
 rtl/axi_stream_protocol_checker.sv | 155 +++++++++++++++
 tb/tb_axi_stream_protocol_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_protocol_checker.sv
// axi_stream_protocol_checker
// Passive AXI4-Stream observer. Flags protocol violations as sticky error bits and keeps
// saturating beat/byte/packet statistics. It never drives the bus.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   tvalid..tuser         monitored stream signals
//   clear                 synchronous clear of err_flags and statistics counters
//   err_flags[5:0]        sticky: valid_drop, payload_change, strb_no_keep, timeout,
//                         route_change, pkt_too_long
//   err_any               registered OR of err_flags
//   beat_count/byte_count/pkt_count  saturating statistics
//   in_packet             high between a non-last handshake and the closing tlast handshake
module axi_stream_protocol_checker #(
  parameter int unsigned BYTE_WIDTH    = 4,
  parameter int unsigned ID_WIDTH      = 1,
  parameter int unsigned DEST_WIDTH    = 1,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned MAX_PKT_BEATS = 0,
  parameter int unsigned INTERLEAVE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic [8*BYTE_WIDTH-1:0] tdata,
  input  logic [BYTE_WIDTH-1:0]   tstrb,
  input  logic [BYTE_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [ID_WIDTH-1:0]     tid,
  input  logic [DEST_WIDTH-1:0]   tdest,
  input  logic [USER_WIDTH-1:0]   tuser,
  input  logic                    clear,
  output logic [5:0]              err_flags,
  output logic                    err_any,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    byte_count,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic                    in_packet
);

  localparam int unsigned PayloadW = 10 * BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int unsigned RouteW   = ID_WIDTH + DEST_WIDTH;
  localparam int unsigned PopW     = $clog2(BYTE_WIDTH + 1);
  localparam int unsigned SumW     = ((CNT_WIDTH > PopW) ? CNT_WIDTH : PopW) + 1;

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  // Add in a wider domain so the increment can never wrap past all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [PopW-1:0]      inc);
    logic [SumW-1:0] sum;
    sum = SumW'(base) + SumW'(inc);
    if (sum > SumW'({CNT_WIDTH{1'b1}})) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic                 hs, stall;
  logic [PayloadW-1:0]  payload, snap_q;
  logic [RouteW-1:0]    route_q;
  logic                 p_stall_q;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [31:0]          pkt_beats_q, beat_num;
  state_e               state_q;
  logic [5:0]           viol, err_q, err_d;
  logic                 err_any_q;
  logic [PopW-1:0]      keep_pop, beat_inc, byte_inc, pkt_inc;
  logic [CNT_WIDTH-1:0] beat_q, byte_q, pkt_q;

  assign hs      = tvalid & tready;
  assign stall   = tvalid & ~tready;
  assign payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < int'(BYTE_WIDTH); i++) keep_pop = keep_pop + PopW'(tkeep[i]);
  end

  assign beat_inc = PopW'(hs);
  assign byte_inc = hs ? keep_pop : '0;
  assign pkt_inc  = PopW'(hs & tlast);

  // Beat number this handshake would occupy within its packet (first beat is 1).
  assign beat_num = (state_q == StInPkt) ?
                    ((pkt_beats_q == '1) ? '1 : pkt_beats_q + 32'd1) : 32'd1;

  assign stall_cnt_d = stall ? ((stall_cnt_q == '1) ? '1 : stall_cnt_q + 32'd1) : '0;

  always_comb begin
    viol    = '0;
    viol[0] = p_stall_q & ~tvalid;
    viol[1] = p_stall_q & tvalid & (payload != snap_q);
    viol[2] = tvalid & (|(tstrb & ~tkeep));
    viol[3] = (TIMEOUT != 0) && stall && (stall_cnt_q == TIMEOUT - 32'd1);
    viol[4] = (INTERLEAVE == 0) && (state_q == StInPkt) && hs && ({tid, tdest} != route_q);
    viol[5] = (MAX_PKT_BEATS != 0) && hs && (beat_num > MAX_PKT_BEATS);
    // A violation in the clear cycle still wins.
    err_d   = (clear ? 6'b0 : err_q) | viol;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_stall_q   <= 1'b0;
      snap_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= '0;
      err_any_q   <= 1'b0;
      beat_q      <= '0;
      byte_q      <= '0;
      pkt_q       <= '0;
    end else begin
      p_stall_q   <= stall;
      snap_q      <= payload;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      err_any_q   <= |err_d;
      beat_q      <= sat_add(clear ? '0 : beat_q, beat_inc);
      byte_q      <= sat_add(clear ? '0 : byte_q, byte_inc);
      pkt_q       <= sat_add(clear ? '0 : pkt_q, pkt_inc);
    end
  end

  // Packet tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      route_q     <= '0;
      pkt_beats_q <= '0;
    end else if (hs) begin
      unique case (state_q)
        StIdle: begin
          if (!tlast) begin
            state_q     <= StInPkt;
            route_q     <= {tid, tdest};
            pkt_beats_q <= 32'd1;
          end
        end
        StInPkt: begin
          pkt_beats_q <= beat_num;
          if (tlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign err_flags  = err_q;
  assign err_any    = err_any_q;
  assign beat_count = beat_q;
  assign byte_count = byte_q;
  assign pkt_count  = pkt_q;
  assign in_packet  = (state_q == StInPkt);

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Bench for axi_stream_protocol_checker: two instances with different parameters share one
// stimulated stream; a rule-level model per instance is compared every cycle, plus literal
// expectations for the directed scenarios.
module tb_axi_stream_protocol_checker;

  localparam int unsigned BW = 4, IW = 2, DW = 2, UW = 1;
  localparam int unsigned CWA = 12, CWB = 2, TMO = 4, MAXB = 2;
  localparam int unsigned PW = 10 * BW + 1 + IW + DW + UW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          tvalid = 0, tready = 0, tlast = 0, clear = 0;
  logic [8*BW-1:0] tdata = '0;
  logic [BW-1:0] tstrb = '0, tkeep = '0;
  logic [IW-1:0] tid = '0;
  logic [DW-1:0] tdest = '0;
  logic [UW-1:0] tuser = '0;

  logic [5:0]     a_err, b_err;
  logic           a_any, b_any, a_inp, b_inp;
  logic [CWA-1:0] a_beat, a_byte, a_pkt;
  logic [CWB-1:0] b_beat, b_byte, b_pkt;

  axi_stream_protocol_checker #(
    .BYTE_WIDTH(BW), .ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CWA),
    .TIMEOUT(TMO), .MAX_PKT_BEATS(0), .INTERLEAVE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
    .clear(clear), .err_flags(a_err), .err_any(a_any), .beat_count(a_beat),
    .byte_count(a_byte), .pkt_count(a_pkt), .in_packet(a_inp)
  );

  axi_stream_protocol_checker #(
    .BYTE_WIDTH(BW), .ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CWB),
    .TIMEOUT(TMO), .MAX_PKT_BEATS(MAXB), .INTERLEAVE(0)
  ) dut_b (
    .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
    .clear(clear), .err_flags(b_err), .err_any(b_any), .beat_count(b_beat),
    .byte_count(b_byte), .pkt_count(b_pkt), .in_packet(b_inp)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]    err;
    int unsigned   beats;
    int unsigned   bytes;
    int unsigned   pkts;
    int unsigned   run;     // consecutive stall cycles including the latest
    bit            pstall;
    logic [PW-1:0] snap;
    bit            inpkt;
    logic [IW+DW-1:0] route;
    int unsigned   pbeats;
  } mstate_t;

  mstate_t ma, mb;

  function automatic int unsigned sat(input int unsigned a, input int unsigned b,
                                      input int unsigned mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int unsigned cmax,
                                    input int unsigned tmo, input int unsigned maxb);
    mstate_t n;
    bit hs, st;
    logic [PW-1:0] pay;
    logic [5:0] v;
    int unsigned num;
    n   = s;
    hs  = tvalid && tready;
    st  = tvalid && !tready;
    pay = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
    v   = '0;
    if (s.pstall && !tvalid) v[0] = 1'b1;
    if (s.pstall && tvalid && pay != s.snap) v[1] = 1'b1;
    if (tvalid && (tstrb & ~tkeep) != '0) v[2] = 1'b1;
    n.run = st ? s.run + 1 : 0;
    if (tmo != 0 && st && n.run == tmo) v[3] = 1'b1;
    num = s.inpkt ? s.pbeats + 1 : 1;
    if (hs && s.inpkt && {tid, tdest} != s.route) v[4] = 1'b1;
    if (hs && maxb != 0 && num > maxb) v[5] = 1'b1;
    n.err   = (clear ? 6'b0 : s.err) | v;
    n.beats = sat(clear ? 0 : s.beats, hs ? 1 : 0, cmax);
    n.bytes = sat(clear ? 0 : s.bytes, hs ? $countones(tkeep) : 0, cmax);
    n.pkts  = sat(clear ? 0 : s.pkts, (hs && tlast) ? 1 : 0, cmax);
    if (hs) begin
      if (tlast) n.inpkt = 1'b0;
      else begin
        if (!s.inpkt) n.route = {tid, tdest};
        n.inpkt  = 1'b1;
        n.pbeats = num;
      end
    end
    n.pstall = st;
    n.snap   = pay;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, (1 << CWA) - 1, TMO, 0);
      mb <= mstep(mb, (1 << CWB) - 1, TMO, MAXB);
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a.err_flags", a_err, ma.err);
      cmp("a.err_any", a_any, |ma.err);
      cmp("a.beat_count", a_beat, ma.beats);
      cmp("a.byte_count", a_byte, ma.bytes);
      cmp("a.pkt_count", a_pkt, ma.pkts);
      cmp("a.in_packet", a_inp, ma.inpkt);
      cmp("b.err_flags", b_err, mb.err);
      cmp("b.err_any", b_any, |mb.err);
      cmp("b.beat_count", b_beat, mb.beats);
      cmp("b.byte_count", b_byte, mb.bytes);
      cmp("b.pkt_count", b_pkt, mb.pkts);
      cmp("b.in_packet", b_inp, mb.inpkt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input bit r, input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] s, input bit l, input logic [1:0] dst, input bit clr);
    tvalid = v; tready = r; tdata = d; tkeep = k; tstrb = s; tlast = l;
    tdest = dst; clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tvalid = 0; tready = 0; tdata = '0; tkeep = '0; tstrb = '0; tlast = 0;
    tid = '0; tdest = '0; tuser = '0; clear = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit ps;
    int hold;
    @(posedge clk);
    chk_en = 1'b1;
    #2;
    reset = 1'b0;
    cmp("reset.err_flags", a_err, 6'h00);
    cmp("reset.beat_count", a_beat, 0);

    // 1: three-beat packet
    do_reset();
    step(1, 1, 32'h11, 4'hF, 4'hF, 0, 2'd1, 0);
    cmp("t1.in_packet_b1", a_inp, 1);
    step(1, 1, 32'h22, 4'hF, 4'hF, 0, 2'd1, 0);
    cmp("t1.in_packet_b2", a_inp, 1);
    step(1, 1, 32'h33, 4'h3, 4'h3, 1, 2'd1, 0);
    cmp("t1.in_packet_end", a_inp, 0);
    cmp("t1.beat_count", a_beat, 3);
    cmp("t1.byte_count", a_byte, 10);
    cmp("t1.pkt_count", a_pkt, 1);
    cmp("t1.err_flags", a_err, 6'h00);
    cmp("t1.model_bytes", ma.bytes, 10);

    // 2: payload changes under stall
    do_reset();
    step(1, 0, 32'hA, 4'hF, 4'hF, 0, 2'd0, 0);
    cmp("t2.err_first", a_err, 6'h00);
    step(1, 0, 32'hB, 4'hF, 4'hF, 0, 2'd0, 0);
    cmp("t2.err_flags", a_err, 6'b000010);
    cmp("t2.err_any", a_any, 1);

    // 3: tvalid withdrawn
    do_reset();
    step(1, 0, 32'h5, 4'hF, 4'hF, 0, 2'd0, 0);
    step(0, 0, 32'h5, 4'hF, 4'hF, 0, 2'd0, 0);
    cmp("t3.err_flags", a_err, 6'b000001);

    // 4: stall watchdog with TIMEOUT=4
    do_reset();
    repeat (3) step(1, 0, 32'h7, 4'hF, 4'hF, 1, 2'd0, 0);
    step(1, 1, 32'h7, 4'hF, 4'hF, 1, 2'd0, 0);
    cmp("t4.no_timeout", a_err, 6'h00);
    repeat (3) step(1, 0, 32'h8, 4'hF, 4'hF, 1, 2'd0, 0);
    cmp("t4.third_stall", a_err, 6'h00);
    step(1, 0, 32'h8, 4'hF, 4'hF, 1, 2'd0, 0);
    cmp("t4.timeout", a_err, 6'b001000);
    cmp("t4.model_timeout", ma.err, 6'b001000);

    // 5: strb without keep, then route change mid-packet
    do_reset();
    step(1, 1, 32'h1, 4'b0001, 4'b0011, 1, 2'd0, 0);
    cmp("t5.strb_no_keep", a_err, 6'b000100);
    step(1, 1, 32'h2, 4'hF, 4'hF, 0, 2'd1, 0);
    step(1, 1, 32'h3, 4'hF, 4'hF, 1, 2'd2, 0);
    cmp("t5.route_change", a_err, 6'b010100);

    // 6: over-long packet on B, clear in the same cycle, counter saturation
    do_reset();
    step(1, 1, 32'h1, 4'hF, 4'hF, 0, 2'd0, 0);
    step(1, 1, 32'h2, 4'hF, 4'hF, 0, 2'd0, 0);
    step(1, 1, 32'h3, 4'hF, 4'hF, 1, 2'd0, 1);
    cmp("t6.too_long", b_err, 6'b100000);
    cmp("t6.beat_after_clear", b_beat, 1);
    repeat (4) step(1, 1, 32'h4, 4'hF, 4'hF, 1, 2'd0, 0);
    cmp("t6.beat_saturated", b_beat, 3);
    cmp("t6.err_kept", b_err, 6'b100000);

    // reset mid-packet: no error for the truncated packet
    do_reset();
    step(1, 1, 32'h1, 4'hF, 4'hF, 0, 2'd1, 0);
    cmp("rst.in_packet", a_inp, 1);
    do_reset();
    cmp("rst.idle", a_inp, 0);
    step(1, 1, 32'h2, 4'hF, 4'hF, 1, 2'd2, 0);
    cmp("rst.no_err", a_err, 6'h00);
    cmp("rst.pkt_count", a_pkt, 1);

    // randomized traffic
    do_reset();
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      ps = tvalid && !tready;
      if ($urandom_range(499, 0) == 0) begin
        do_reset();
        ps = 0;
      end
      if (!(ps && $urandom_range(19, 0) != 0)) begin
        tvalid = ($urandom_range(3, 0) != 0);
        tdata  = $urandom;
        tkeep  = 4'($urandom);
        tstrb  = ($urandom_range(19, 0) == 0) ? 4'($urandom) : tkeep;
        tlast  = ($urandom_range(2, 0) == 0);
        tuser  = 1'($urandom);
        if ($urandom_range(9, 0) == 0) tid = 2'($urandom);
        if ($urandom_range(9, 0) == 0) tdest = 2'($urandom);
      end
      if (hold > 0) begin
        tready = 1'b0;
        hold--;
      end else begin
        tready = ($urandom_range(2, 0) != 0);
        if ($urandom_range(49, 0) == 0) hold = $urandom_range(6, 3);
      end
      clear = ($urandom_range(39, 0) == 0);
      @(posedge clk);
      #2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
